phase_sequencer: RTL and testbench

Generates the 3-bit `phase` value consumed by the processor control unit and owns the run/stop behaviour of the CPU. It conditions the raw `exec` push-button with a synchroniser and debouncer, then steps phases 1→5 once per cycle while running. It stops cleanly at an instruction boundary on an `exec` press, on single-step mode, or when the control unit raises `stop_flag` (HLT). It sits directly upstream of the control unit and drives `phase` into it.

---
 rtl/phase_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_phase_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Produces the 3-bit instruction phase for the processor control unit and owns
// the CPU run/stop behaviour. The raw exec push-button is synchronised and
// debounced; each debounced press either starts execution from idle or asks
// the running CPU to stop at the next instruction boundary.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   exec         raw push-button, active high, asynchronous to clk
//   step_mode    level, 1 = stop after every instruction
//   stop_flag    HLT request from the control unit, looked at only in phase 5
//   phase        0 = idle, 1..5 = instruction phases (registered)
//   running      registered copy of (phase != 0)
//   halted       sticky, set when the last stop came from stop_flag
//   instr_done   high during the phase-5 cycle of every instruction
//   instr_count  completed instruction count, wraps at 16 bits
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exec,
    input  logic        step_mode,
    input  logic        stop_flag,
    output logic [2:0]  phase,
    output logic        running,
    output logic        halted,
    output logic        instr_done,
    output logic [15:0] instr_count
);

    localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Input conditioning state
    logic            s1_q;
    logic            s_q;
    logic            db_q, db_d;
    logic            db_dly_q;
    logic [DC_W-1:0] dc_q, dc_d;

    // Sequencer state
    state_e          state_q, state_d;
    logic [2:0]      phase_q, phase_d;
    logic            running_q, running_d;
    logic            halted_q, halted_d;
    logic            instr_done_q, instr_done_d;
    logic [15:0]     count_q, count_d;
    logic            stop_req_q, stop_req_d;

    logic            exec_pulse_s;
    logic            stop_now_s;

    // A press is the rising edge of the debounced level; release makes no pulse.
    assign exec_pulse_s = db_q & ~db_dly_q;

    // Any of these ends execution at the phase-5 boundary.
    assign stop_now_s = stop_flag | step_mode | stop_req_q | exec_pulse_s;

    // Debounce counter: the level only follows s after it has disagreed with
    // db for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
    always_comb begin
        db_d = db_q;
        dc_d = dc_q;
        if (s_q == db_q) begin
            dc_d = '0;
        end else if (dc_q == DC_LAST) begin
            db_d = s_q;
            dc_d = '0;
        end else begin
            dc_d = dc_q + DC_W'(1);
        end
    end

    // Synchroniser, debounced level and its one-cycle delayed copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s_q      <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            dc_q     <= '0;
        end else begin
            s1_q     <= exec;
            s_q      <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            dc_q     <= dc_d;
        end
    end

    // Next-state and next-output logic of the run/stop sequencer.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        halted_d   = halted_q;
        count_d    = count_q;
        stop_req_d = stop_req_q;

        case (state_q)
            ST_IDLE: begin
                if (exec_pulse_s) begin
                    state_d    = ST_RUN;
                    phase_d    = 3'd1;
                    halted_d   = 1'b0;
                    stop_req_d = 1'b0;
                end else begin
                    phase_d    = 3'd0;
                end
            end
            ST_RUN: begin
                case (phase_q)
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        // A press mid-instruction is remembered, never aborts.
                        phase_d = phase_q + 3'd1;
                        if (exec_pulse_s) begin
                            stop_req_d = 1'b1;
                        end else begin
                            stop_req_d = stop_req_q;
                        end
                    end
                    3'd5: begin
                        count_d = count_q + 16'd1;
                        if (stop_now_s) begin
                            state_d    = ST_IDLE;
                            phase_d    = 3'd0;
                            stop_req_d = 1'b0;
                            halted_d   = halted_q | stop_flag;
                        end else begin
                            phase_d    = 3'd1;
                        end
                    end
                    default: begin
                        // Phases 0, 6 and 7 cannot occur while running; recover to idle.
                        state_d    = ST_IDLE;
                        phase_d    = 3'd0;
                        stop_req_d = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d    = ST_IDLE;
                phase_d    = 3'd0;
                stop_req_d = 1'b0;
            end
        endcase

        // Flags are derived from the next phase so they register alongside it.
        running_d    = (phase_d != 3'd0);
        instr_done_d = (phase_d == 3'd5);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 3'd0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            instr_done_q <= 1'b0;
            count_q      <= 16'd0;
            stop_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
            instr_done_q <= instr_done_d;
            count_q      <= count_d;
            stop_req_q   <= stop_req_d;
        end
    end

    assign phase       = phase_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign instr_done  = instr_done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Directed bench for phase_sequencer with DEBOUNCE_CYCLES = 4. The stimulus
// process queues the expected phase sequence and the expected instr_count seen
// at each instr_done; a monitor process pops and compares them on every
// falling edge while the sequencer is running.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exec = 1'b0;
    logic        step_mode = 1'b0;
    logic        stop_flag = 1'b0;
    logic [2:0]  phase;
    logic        running;
    logic        halted;
    logic        instr_done;
    logic [15:0] instr_count;

    int          nchk = 0;
    int          nfail = 0;
    logic [2:0]  exp_ph[$];
    logic [15:0] exp_done[$];
    logic [2:0]  mon_ph;
    logic        db_rose;

    phase_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .exec        (exec),
        .step_mode   (step_mode),
        .stop_flag   (stop_flag),
        .phase       (phase),
        .running     (running),
        .halted      (halted),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (dut.db_q) db_rose = 1'b1;
    endtask

    task automatic push_instr(input logic [15:0] cnt_before);
        for (int p = 1; p <= 5; p++) exp_ph.push_back(3'(p));
        exp_done.push_back(cnt_before);
    endtask

    // Button held high for six clean cycles, then released.
    task automatic press6();
        exec = 1'b1;
        repeat (6) tick();
        exec = 1'b0;
    endtask

    task automatic wait_for(input logic [2:0] ph, input int cnt, input string nm);
        int t;
        t = 0;
        while (!(phase == ph && (cnt < 0 || int'(instr_count) == cnt)) && t < 100) begin
            tick();
            t++;
        end
        chk(nm, 32'(t < 100), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (running) begin
                if (exp_ph.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL run_unexpected actual_phase=%0d expected=idle at %0t", phase, $time);
                end else begin
                    mon_ph = exp_ph.pop_front();
                    chk("phase", 32'(phase), 32'(mon_ph));
                    chk("instr_done", 32'(instr_done), 32'(mon_ph == 3'd5));
                end
            end else begin
                chk("idle_phase", 32'(phase), 32'd0);
                chk("idle_done", 32'(instr_done), 32'd0);
            end
            if (instr_done) begin
                if (exp_done.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL done_unexpected actual_count=%0h at %0t", instr_count, $time);
                end else begin
                    chk("count_at_done", 32'(instr_count), 32'(exp_done.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        db_rose = 1'b0;
        // ---- reset state, start latency, free run, HLT on the 3rd instruction
        exec = 1'b1;
        tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_done", 32'(instr_done), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        push_instr(16'd0);
        push_instr(16'd1);
        push_instr(16'd2);
        rst = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk("start_latency", 32'(phase), 32'd0);
        end
        wait_for(3'd5, 2, "wait_hlt_phase5");
        stop_flag = 1'b1;
        tick();
        stop_flag = 1'b0;
        chk("hlt_phase", 32'(phase), 32'd0);
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_count", 32'(instr_count), 32'd3);
        chk("hlt_queue", 32'(exp_ph.size()), 32'd0);
        exec = 1'b0;
        repeat (10) tick();
        chk("release_no_start", 32'(phase), 32'd0);

        // ---- bounce rejection
        db_rose = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exec = 1'b1;
            repeat (1 + (i % 3)) tick();
            exec = 1'b0;
            repeat (1 + (i % 2)) tick();
        end
        repeat (8) tick();
        chk("bounce_db", 32'(db_rose), 32'd0);
        chk("bounce_phase", 32'(phase), 32'd0);
        chk("bounce_halted", 32'(halted), 32'd1);

        // ---- clean start, then a press landing in phase 2 stops the run
        push_instr(16'd3);
        push_instr(16'd4);
        push_instr(16'd5);
        press6();
        wait_for(3'd1, 4, "wait_instr5");
        chk("halted_cleared", 32'(halted), 32'd0);
        press6();
        wait_for(3'd0, 6, "wait_press_stop");
        chk("press_stop_halted", 32'(halted), 32'd0);
        chk("press_stop_count", 32'(instr_count), 32'd6);
        chk("press_stop_queue", 32'(exp_ph.size()), 32'd0);
        repeat (10) tick();
        chk("press_stop_idle", 32'(phase), 32'd0);

        // ---- step mode, stop_flag outside phase 5 ignored
        rst = 1'b0;
        #1;
        chk("rst2_count", 32'(instr_count), 32'd0);
        tick();
        rst = 1'b1;
        step_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            push_instr(16'(r));
            if (r == 2) begin
                stop_flag = 1'b1;
                repeat (2) tick();
                stop_flag = 1'b0;
            end
            press6();
            if (r == 1) begin
                wait_for(3'd3, 1, "wait_step_p3");
                stop_flag = 1'b1;
                tick();
                stop_flag = 1'b0;
            end
            wait_for(3'd0, r + 1, "wait_step_stop");
            chk("step_halted", 32'(halted), 32'd0);
            repeat (3) tick();
        end
        chk("step_count", 32'(instr_count), 32'd4);

        // ---- counter wrap
        force dut.count_q = 16'hFFFF;
        repeat (2) tick();
        release dut.count_q;
        tick();
        chk("preload", 32'(instr_count), 32'hFFFF);
        push_instr(16'hFFFF);
        press6();
        wait_for(3'd0, 0, "wait_wrap");
        chk("wrap_count", 32'(instr_count), 32'd0);
        repeat (3) tick();

        // ---- asynchronous reset in phase 3
        exp_ph.push_back(3'd1);
        exp_ph.push_back(3'd2);
        exp_ph.push_back(3'd3);
        press6();
        wait_for(3'd3, 0, "wait_p3_reset");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_done", 32'(instr_done), 32'd0);
        chk("arst_count", 32'(instr_count), 32'd0);
        chk("arst_queue", 32'(exp_ph.size()), 32'd0);
        exp_ph.delete();
        exp_done.delete();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("post_rst_phase", 32'(phase), 32'd0);
        chk("post_rst_count", 32'(instr_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
